// File: rtl/hilo_sequencer.sv
// HI/LO register sequencer for an iterative multiplier: runs MULTU for MUL_CYCLES cycles, latches the product, serves MFHI/MFLO reads.
// Optional MTHI/MTLO writes are enabled by defining HILO_MOVE_TO_EN.
module hilo_sequencer #(
  parameter int unsigned MUL_CYCLES = 32,
  parameter logic [5:0]  MULTU      = 6'b011001,
  parameter logic [5:0]  MFHI       = 6'b010000,
  parameter logic [5:0]  MFLO       = 6'b010010,
  parameter logic [5:0]  MTHI       = 6'b010001,
  parameter logic [5:0]  MTLO       = 6'b010011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Signal,
  input  logic [63:0] prodIn,
  input  logic [31:0] dataIn,
  output logic        mulReset,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataOut
);

  localparam int unsigned CW = $clog2(MUL_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LATCH
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   hi, lo;

`ifndef HILO_MOVE_TO_EN
  logic unused_datain;
  assign unused_datain = ^dataIn;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (Signal == MULTU) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(MUL_CYCLES - 1)) state_nxt = LATCH;
      end
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The multiplier is held clear everywhere except while it accumulates.
  always_comb begin
    mulReset = (state != RUN);
    busy     = (state == RUN) || (state == LATCH);
    done     = (state == LATCH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      dataOut <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == LATCH) begin
        hi <= prodIn[63:32];
        lo <= prodIn[31:0];
      end
`ifdef HILO_MOVE_TO_EN
      else if (state == IDLE && Signal == MTHI) hi <= dataIn;
      else if (state == IDLE && Signal == MTLO) lo <= dataIn;
`endif
      // Reads see the register value before any update at this edge.
      if (Signal == MFHI)      dataOut <= hi;
      else if (Signal == MFLO) dataOut <= lo;
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Scoreboard bench for hilo_sequencer: the stimulus process predicts outputs per edge, the monitor compares at negedge.
module tb_hilo_sequencer;

  localparam int unsigned MC    = 32;
  localparam logic [5:0]  MULTU = 6'b011001;
  localparam logic [5:0]  MFHI  = 6'b010000;
  localparam logic [5:0]  MFLO  = 6'b010010;
  localparam logic [5:0]  MTHI  = 6'b010001;
  localparam logic [5:0]  MTLO  = 6'b010011;
  localparam logic [5:0]  NOP   = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Signal;
  logic [63:0] prodIn;
  logic [31:0] dataIn;
  logic        mulReset, busy, done;
  logic [31:0] dataOut;

  always #5 clk = ~clk;

  hilo_sequencer #(
    .MUL_CYCLES(MC),
    .MULTU(MULTU),
    .MFHI(MFHI),
    .MFLO(MFLO),
    .MTHI(MTHI),
    .MTLO(MTLO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Signal(Signal),
    .prodIn(prodIn),
    .dataIn(dataIn),
    .mulReset(mulReset),
    .busy(busy),
    .done(done),
    .dataOut(dataOut)
  );

  typedef struct {
    int unsigned edge_n;
    logic        busy;
    logic        done;
    logic        mulr;
    logic [31:0] dout;
  } exp_t;

  exp_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: architectural HI/LO plus the edge index at which the current multiply started.
  logic [31:0] m_hi = '0, m_lo = '0, m_dout = '0;
  bit          m_act = 1'b0;
  int unsigned m_s = 0, m_edge = 0;

  task automatic chk(input string name, input int unsigned e, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, e, act, expv);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] sig, input logic [63:0] prod, input logic [31:0] din);
    exp_t        e;
    int unsigned k;
`ifdef HILO_MOVE_TO_EN
    bit          act_pre;
    act_pre = m_act;
`endif
    reset  = r;
    Signal = sig;
    prodIn = prod;
    dataIn = din;
    if (!r) begin
      m_hi = '0; m_lo = '0; m_dout = '0; m_act = 1'b0;
    end else begin
      if (sig == MFHI)      m_dout = m_hi;
      else if (sig == MFLO) m_dout = m_lo;
      if (m_act && (m_edge - m_s == MC + 1)) begin
        m_hi  = prod[63:32];
        m_lo  = prod[31:0];
        m_act = 1'b0;
      end else if (!m_act && sig == MULTU) begin
        m_act = 1'b1;
        m_s   = m_edge;
      end
`ifdef HILO_MOVE_TO_EN
      if (!act_pre && sig == MTHI) m_hi = din;
      if (!act_pre && sig == MTLO) m_lo = din;
`endif
    end
    k        = m_edge - m_s;
    e.edge_n = m_edge;
    e.busy   = m_act;
    e.done   = m_act && (k == MC);
    e.mulr   = !(m_act && (k < MC));
    e.dout   = m_dout;
    q.push_back(e);
    m_edge++;
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int unsigned n, input logic [63:0] prod);
    for (int unsigned i = 0; i < n; i++) step(1'b1, NOP, prod, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got no expectation, expected one per edge");
      end else begin
        e = q.pop_front();
        chk("busy",     e.edge_n, {31'b0, busy},     {31'b0, e.busy});
        chk("done",     e.edge_n, {31'b0, done},     {31'b0, e.done});
        chk("mulReset", e.edge_n, {31'b0, mulReset}, {31'b0, e.mulr});
        chk("dataOut",  e.edge_n, dataOut,           e.dout);
      end
    end
  end

  initial begin : stimulus
    logic [63:0] p;
    logic [5:0]  sig;
    logic        r;

    step(1'b0, NOP, 64'h0, 32'h0);
    step(1'b0, NOP, 64'h0, 32'h0);
    step(1'b1, MFHI, 64'h0, 32'h0);
    step(1'b1, MFLO, 64'h0, 32'h0);

    p = 64'h0000_0001_0000_0002;
    step(1'b1, MULTU, p, 32'h0);
    nops(MC + 1, p);
    step(1'b1, MFHI, p, 32'h0);
    step(1'b1, MFLO, p, 32'h0);

    // Second MULTU while busy must be ignored.
    p = 64'h1111_2222_3333_4444;
    step(1'b1, MULTU, p, 32'h0);
    nops(4, p);
    step(1'b1, MULTU, p, 32'h0);
    nops(MC + 1 - 5, p);
    step(1'b1, MFLO, p, 32'h0);

    p = 64'h0000_0001_0000_0002;
    step(1'b1, MULTU, p, 32'h0);
    nops(MC + 1, p);
    p = 64'hAAAA_0005_BBBB_0006;
    step(1'b1, MULTU, p, 32'h0);
    nops(3, p);
    step(1'b1, MFLO, p, 32'h0);
    nops(MC + 1 - 4, p);
    step(1'b1, MFLO, p, 32'h0);
    step(1'b1, MFHI, p, 32'h0);

    // Back-to-back multiplies with one idle cycle, then reset mid-run.
    step(1'b1, MULTU, p, 32'h0);
    nops(MC + 1, p);
    step(1'b1, MULTU, ~p, 32'h0);
    nops(9, ~p);
    step(1'b0, NOP, ~p, 32'h0);
    nops(MC + 4, ~p);
    step(1'b1, MFHI, ~p, 32'h0);
    step(1'b1, MFLO, ~p, 32'h0);

    step(1'b1, MTHI, 64'h0, 32'hDEAD_BEEF);
    step(1'b1, MFHI, 64'h0, 32'h0);
    step(1'b1, MTLO, 64'h0, 32'h1234_5678);
    step(1'b1, MFLO, 64'h0, 32'h0);

    for (int unsigned i = 0; i < 3000; i++) begin
      r = ($urandom % 300) != 0;
      case ($urandom % 8)
        0:       sig = MULTU;
        1:       sig = MFHI;
        2:       sig = MFLO;
        3:       sig = MTHI;
        4:       sig = MTLO;
        default: sig = 6'($urandom);
      endcase
      step(r, sig, {$urandom, $urandom}, $urandom);
    end
    step(1'b1, MFHI, 64'h0, 32'h0);
    step(1'b1, MFLO, 64'h0, 32'h0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 0, q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_sequencer.md
HILO_SEQUENCER -- requirements
Module: hilo_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 32, number of multiplier accumulate cycles per MULTU.
REQ-002 SHALL have parameter MULTU, default 6'b011001, Signal code that starts a multiply.
REQ-003 SHALL have parameter MFHI, default 6'b010000, Signal code that reads HI.
REQ-004 SHALL have parameter MFLO, default 6'b010010, Signal code that reads LO.
REQ-005 SHALL have parameter MTHI, default 6'b010001, Signal code that writes HI (macro-gated).
REQ-006 SHALL have parameter MTLO, default 6'b010011, Signal code that writes LO (macro-gated).
REQ-007 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-009 SHALL have port Signal  input  6  operation code, sampled every rising edge.
REQ-010 SHALL have port prodIn  input  64  product from the downstream multiplier's dataOut.
REQ-011 SHALL have port dataIn  input  32  move-to operand; ignored unless HILO_MOVE_TO_EN is defined.
REQ-012 SHALL have port mulReset  output  1  active-high clear to the multiplier's reset.
REQ-013 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port dataOut  output  32  registered HI/LO read value.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, LATCH, plus a counter of ceil(log2(MUL_CYCLES))+1 bits.
REQ-017 IDLE: Signal==MULTU at an edge -> RUN with counter cleared to 0; otherwise stay IDLE.
REQ-018 RUN: counter increments each edge; at the edge where counter==MUL_CYCLES-1 -> LATCH, so RUN lasts exactly MUL_CYCLES cycles.
REQ-019 LATCH: lasts exactly one cycle, always -> IDLE; at that edge HI<=prodIn[63:32] and LO<=prodIn[31:0].
REQ-020 mulReset SHALL equal 1 in every state except RUN, so the multiplier is held clear until RUN.
REQ-021 busy SHALL be 1 in RUN and LATCH, 0 in IDLE; done SHALL be 1 only in LATCH.
REQ-022 Latency: MULTU sampled at edge E0 -> done high during cycle E(MUL_CYCLES) to E(MUL_CYCLES+1); new HI/LO visible after E(MUL_CYCLES+1).
REQ-023 Signal==MFHI (MFLO) at any edge, in any state, SHALL load dataOut with the current HI (LO); otherwise dataOut holds.
REQ-024 A read sampled in RUN or LATCH SHALL return the pre-multiply HI/LO value (no bypass of prodIn).
REQ-025 MULTU sampled while busy SHALL be ignored: no restart, no counter change.
REQ-026 MULTU in the cycle after LATCH (state IDLE) SHALL be accepted, giving back-to-back operation with one idle cycle.
REQ-027 Unrecognised Signal codes SHALL have no effect.

Reset
REQ-028 reset==0 at a rising edge SHALL force: state IDLE, counter 0, HI 0, LO 0, dataOut 0, busy 0, done 0, mulReset 1.
REQ-029 Reset asserted mid-RUN or in LATCH SHALL abort the multiply; no HI/LO write occurs.
REQ-030 reset SHALL take priority over every Signal code at the same edge.

Configuration
REQ-031 With HILO_MOVE_TO_EN defined: MTHI (MTLO) sampled in IDLE SHALL write dataIn into HI (LO) at that edge; ignored while busy.
REQ-032 Without HILO_MOVE_TO_EN: MTHI/MTLO SHALL be treated as unrecognised codes, and dataIn SHALL be unused.

Verification
REQ-033 Reset low for 2 edges, then high -> busy=0, done=0, mulReset=1, dataOut=0; MFHI then MFLO both read 0.
REQ-034 MULTU at E0, bench drives prodIn=64'h0000_0001_0000_0002 during LATCH -> done high in cycle 32 only; MFHI reads 32'h1 and MFLO reads 32'h2.
REQ-035 MULTU at E0, second MULTU at E5 -> single done pulse at cycle 32, and busy stays continuously high from E0 to E33.
REQ-036 HI=1 and LO=2 from the previous test, new MULTU, MFLO issued during RUN -> dataOut=32'h2 (old value); after done, MFLO returns the new LO.
REQ-037 reset low at E10 of a multiply -> IDLE at the next cycle, no done pulse, HI=LO=0.
REQ-038 With HILO_MOVE_TO_EN: MTHI with dataIn=32'hDEAD_BEEF, then MFHI -> dataOut=32'hDEAD_BEEF; without the macro, the same sequence -> dataOut=32'h0.
